stage_sequencer: RTL and testbench

STAGE_SEQUENCER -- requirements
Module: stage_sequencer

---
 rtl/stage_sequencer.sv | 160 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - six-stage instruction sequencer with per-stage timeout and perf counters
// Optional single-step PAUSE after each retired instruction: define SINGLE_STEP_EN.
module stage_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             fetch_done,
    input  logic             decode_done,
    input  logic             exec_done,
    input  logic             mem_done,
    input  logic             wb_done,
    input  logic             pc_done,
    input  logic [1:0]       stat,
    input  logic             mem_err,
    output logic             fetch_start,
    output logic             decode_start,
    output logic             exec_start,
    output logic             mem_start,
    output logic             wb_start,
    output logic             pc_start,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, PCUPD, HALT, ERROR
`ifdef SINGLE_STEP_EN
        , PAUSE
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [TW-1:0]    tcnt_q;
    logic [5:0]       start_q;
    logic             busy_q, halted_q, error_q;
    logic [CNT_W-1:0] instr_q, cycle_q;
    logic             stage_done, done_acc, expired;

    function automatic logic is_stage(input state_t s);
        return s inside {FETCH, DECODE, EXEC, MEM, WB, PCUPD};
    endfunction

    always_comb begin
        case (state_q)
            FETCH:   stage_done = fetch_done;
            DECODE:  stage_done = decode_done;
            EXEC:    stage_done = exec_done;
            MEM:     stage_done = mem_done;
            WB:      stage_done = wb_done;
            PCUPD:   stage_done = pc_done;
            default: stage_done = 1'b0;
        endcase
    end

    // tcnt_q is zero only in the start cycle, so a done coinciding with start is dropped
    assign done_acc = stage_done && (tcnt_q != '0);
    assign expired  = (tcnt_q == T_LAST);

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            IDLE:   if (run) state_d = FETCH;
            FETCH:  if (done_acc) begin
                case (stat)
                    2'd0: state_d = DECODE;
                    2'd1: state_d = HALT;
                    2'd2: begin state_d = ERROR; err_code_d = 2'd1; end
                    default: begin state_d = ERROR; err_code_d = 2'd2; end
                endcase
            end
            DECODE: if (done_acc) state_d = EXEC;
            EXEC:   if (done_acc) state_d = MEM;
            MEM:    if (done_acc) begin
                if (mem_err) begin
                    state_d    = ERROR;
                    err_code_d = 2'd1;
                end else begin
                    state_d = WB;
                end
            end
            WB:     if (done_acc) state_d = PCUPD;
            PCUPD:  if (done_acc) begin
`ifdef SINGLE_STEP_EN
                state_d = run ? PAUSE : IDLE;
`else
                state_d = run ? FETCH : IDLE;
`endif
            end
`ifdef SINGLE_STEP_EN
            PAUSE:  if (!run) state_d = IDLE;
                    else if (step) state_d = FETCH;
`endif
            default: ;
        endcase
        // an accepted done in the expiry cycle has already chosen state_d and wins
        if (is_stage(state_q) && !done_acc && expired) begin
            state_d    = ERROR;
            err_code_d = 2'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            err_code_q <= 2'd0;
            tcnt_q     <= '0;
            start_q    <= '0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
            instr_q    <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            tcnt_q     <= (state_d == state_q && is_stage(state_q)) ? tcnt_q + TW'(1) : '0;
            start_q[0] <= (state_d != state_q) && (state_d == FETCH);
            start_q[1] <= (state_d != state_q) && (state_d == DECODE);
            start_q[2] <= (state_d != state_q) && (state_d == EXEC);
            start_q[3] <= (state_d != state_q) && (state_d == MEM);
            start_q[4] <= (state_d != state_q) && (state_d == WB);
            start_q[5] <= (state_d != state_q) && (state_d == PCUPD);
            busy_q     <= is_stage(state_d);
            halted_q   <= (state_d == HALT);
            error_q    <= (state_d == ERROR);
            if (state_q == PCUPD && done_acc && !(&instr_q))
                instr_q <= instr_q + CNT_W'(1);
            if (busy_q && !(&cycle_q))
                cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign fetch_start  = start_q[0];
    assign decode_start = start_q[1];
    assign exec_start   = start_q[2];
    assign mem_start    = start_q[3];
    assign wb_start     = start_q[4];
    assign pc_start     = start_q[5];
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign instr_count  = instr_q;
    assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - randomized self-checking bench for stage_sequencer
// Define SINGLE_STEP_EN to exercise the PAUSE/step path.
module tb_stage_sequencer;
    localparam int TO = 16;
    localparam int CW = 32;

    logic clock = 1'b0;
    logic reset, run, mem_err;
    logic fetch_done, decode_done, exec_done, mem_done, wb_done, pc_done;
    logic [1:0] stat;
`ifdef SINGLE_STEP_EN
    logic step;
`endif
    logic fetch_start, decode_start, exec_start, mem_start, wb_start, pc_start;
    logic busy, halted, error;
    logic [1:0] err_code;
    logic [CW-1:0] instr_count, cycle_count;

    stage_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .fetch_done(fetch_done), .decode_done(decode_done), .exec_done(exec_done),
        .mem_done(mem_done), .wb_done(wb_done), .pc_done(pc_done),
        .stat(stat), .mem_err(mem_err),
        .fetch_start(fetch_start), .decode_start(decode_start), .exec_start(exec_start),
        .mem_start(mem_start), .wb_start(wb_start), .pc_start(pc_start),
        .busy(busy), .halted(halted), .error(error), .err_code(err_code),
        .instr_count(instr_count), .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    int         lat [6];
    longint     exp_instr, exp_cycles;
    logic [5:0] starts;
    int         outcome;

    assign starts = {pc_start, wb_start, mem_start, exec_start, decode_start, fetch_start};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_done(input logic [5:0] v);
        {pc_done, wb_done, mem_done, exec_done, decode_done, fetch_done} = v;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_instr"}, instr_count, exp_instr);
        check({tag, "_cycles"}, cycle_count, exp_cycles);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        stat  = 2'd0;
        mem_err = 1'b0;
        set_done('0);
`ifdef SINGLE_STEP_EN
        step = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        exp_instr  = 0;
        exp_cycles = 0;
        check("rst_starts", starts, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        check("rst_code", err_code, 0);
        check_counts("rst");
    endtask

    task automatic all_lat(input int v);
        for (int s = 0; s < 6; s++) lat[s] = v;
    endtask

    // lat[s] = cycles from start to done; lat >= TO means the done never comes.
    // Entered at the negedge where fetch_start should be high; leaves at the negedge after the end.
    task automatic run_instr(input logic [1:0] st, input logic merr, input logic run_end,
                             input int run_drop, output int res);
        int dur;
        bit tmo;
        res = 0;
        for (int s = 0; s < 6; s++) begin
            check($sformatf("start_s%0d", s), starts, 6'd1 << s);
            check("busy_stage", busy, 1);
            if (s == run_drop) run = run_end;
            tmo = lat[s] > TO - 1;
            dur = tmo ? TO : lat[s] + 1;
            set_done(6'($urandom));
            stat    = 2'($urandom);
            mem_err = 1'($urandom);
            for (int c = 2; c <= dur; c++) begin
                tick();
                set_done('0);
                if (c == 2) check("start_single", starts, 0);
                if (c == dur) begin
                    check("no_err_early", error, 0);
                    if (!tmo) begin
                        set_done(6'd1 << s);
                        stat    = st;
                        mem_err = merr;
                    end
                end
            end
            tick();
            set_done('0);
            exp_cycles += dur;
            if (tmo) begin
                check("tmo_error", error, 1);
                check("tmo_code", err_code, 3);
                res = 2;
            end else if (s == 0 && st == 2'd1) begin
                check("halt_flag", halted, 1);
                res = 1;
            end else if (s == 0 && st != 2'd0) begin
                check("fetch_error", error, 1);
                check("fetch_code", err_code, 64'(st) - 1);
                res = 2;
            end else if (s == 3 && merr) begin
                check("mem_error", error, 1);
                check("mem_code", err_code, 1);
                res = 2;
            end
            if (res != 0) begin
                check("stop_starts", starts, 0);
                check("stop_busy", busy, 0);
                break;
            end
        end
        if (res == 0) begin
            exp_instr++;
            if (!run_end) begin
                check("idle_busy", busy, 0);
                check("idle_starts", starts, 0);
            end
`ifdef SINGLE_STEP_EN
            else begin
                check("pause_busy", busy, 0);
                check("pause_starts", starts, 0);
            end
`endif
        end
        check_counts("instr");
    endtask

    // HALT/ERROR must stay put with no start pulses and frozen counters
    task automatic absorb_check(input int n, input int res);
        logic [5:0] seen;
        seen = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen |= starts;
        end
        check("absorb_starts", seen, 0);
        check("absorb_halted", halted, res == 1);
        check("absorb_error", error, res == 2);
        check_counts("absorb");
    endtask

`ifdef SINGLE_STEP_EN
    task automatic step_resume(input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            tick();
            check("pause_hold", {starts, busy}, 0);
        end
        check("pause_cycles", cycle_count, exp_cycles);
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask
`endif

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] st;
        logic       merr, run_end;
        int         r;

        // three back-to-back minimum-latency instructions
        do_reset();
        all_lat(1);
        run = 1'b1;
        tick();
        run_instr(2'd0, 1'b0, 1'b1, -1, outcome);
`ifdef SINGLE_STEP_EN
        step_resume(2);
`endif
        run_instr(2'd0, 1'b0, 1'b1, -1, outcome);
`ifdef SINGLE_STEP_EN
        step_resume(0);
`endif
        run_instr(2'd0, 1'b0, 1'b0, 2, outcome);
        check("dir_cycles36", cycle_count, 36);
        check("dir_instr3", instr_count, 3);
        check("dir_noerr", error, 0);

        // HALT absorbs, reset clears it
        run = 1'b1;
        tick();
        run_instr(2'd1, 1'b0, 1'b1, -1, outcome);
        absorb_check(50, 1);
        do_reset();

        // data-memory error, then instruction fault code
        run = 1'b1;
        tick();
        run_instr(2'd0, 1'b1, 1'b1, -1, outcome);
        absorb_check(10, 2);
        do_reset();
        run = 1'b1;
        tick();
        run_instr(2'd3, 1'b0, 1'b1, -1, outcome);
        absorb_check(5, 2);
        do_reset();

        // exec timeout, then exec_done landing in the expiry cycle
        run = 1'b1;
        tick();
        lat[2] = TO;
        run_instr(2'd0, 1'b0, 1'b1, -1, outcome);
        absorb_check(5, 2);
        do_reset();
        run = 1'b1;
        tick();
        lat[2] = TO - 1;
        run_instr(2'd0, 1'b0, 1'b0, 0, outcome);
        check("expiry_noerr", error, 0);
        all_lat(1);

        // reset beats run and done pulses mid-stage
        run = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        set_done('1);
        tick();
        check("rstpri_busy", busy, 0);
        check("rstpri_starts", starts, 0);
        check("rstpri_cycles", cycle_count, 0);
        do_reset();

`ifdef SINGLE_STEP_EN
        // run=0 with step from PAUSE lands in IDLE; IDLE then reacts to run alone
        run = 1'b1;
        tick();
        run_instr(2'd0, 1'b0, 1'b1, -1, outcome);
        run  = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        check("pause_to_idle_busy", busy, 0);
        run = 1'b1;
        tick();
        check("idle_then_fetch", fetch_start, 1);
        do_reset();
`endif

        // randomized instruction stream
        run = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 6; s++) begin
                r = $urandom_range(0, 99);
                lat[s] = (r < 92) ? $urandom_range(1, 3) : (r < 98) ? TO - 1 : TO;
            end
            r       = $urandom_range(0, 39);
            st      = (r < 3) ? 2'(r + 1) : 2'd0;
            merr    = ($urandom_range(0, 29) == 0);
            run_end = ($urandom_range(0, 3) != 0);
            run_instr(st, merr, run_end, $urandom_range(0, 5), outcome);
            if (outcome != 0) begin
                absorb_check(20, outcome);
                do_reset();
                run = 1'b1;
                tick();
            end else if (!run_end) begin
                tick();
                check("idle_stays", starts, 0);
                run = 1'b1;
                tick();
            end
`ifdef SINGLE_STEP_EN
            else begin
                step_resume($urandom_range(0, 3));
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
